// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - aligning load/store unit between core datapath and a wait-stated data memory
module load_store_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    output logic              o_req_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_err,
    output logic              o_misalign,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    input  logic              i_mem_err,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_wstrb,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic [XLEN-1:0]   i_mem_rdata
);
    localparam int LANES = XLEN / 8;
    localparam int OFS_W = $clog2(LANES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [OFS_W-1:0] r_off;
    logic             r_split;
    logic [LANES-1:0] r_wstrb_hi;
    logic [XLEN-1:0]  r_wdata_hi;
    logic [XLEN-1:0]  r_rd0;

    logic [OFS_W-1:0]   in_off;
    logic [ADDR_W-1:0]  in_base;
    logic [2*LANES-1:0] in_strb2;
    logic [2*XLEN-1:0]  in_data2;
    logic               in_illegal;
    logic               in_misalign;
    logic               in_split;
    logic               in_reject;

    logic [XLEN-1:0] rd_lo;
    logic [XLEN-1:0] rd_hi;
    logic [XLEN-1:0] rd_merged;
    logic [XLEN-1:0] load_result;

    // One strobe bit per byte of the access size, right-aligned.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = LANES'(8'h01);
            2'd1:    size_mask = LANES'(8'h03);
            2'd2:    size_mask = LANES'(8'h0F);
            default: size_mask = LANES'(8'hFF);
        endcase
    endfunction

    // Truncate to the access size, then sign- or zero-extend (funct3[2] = unsigned).
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    extend = f3[2] ? XLEN'(v[7:0])  : XLEN'($signed(v[7:0]));
            2'd1:    extend = f3[2] ? XLEN'(v[15:0]) : XLEN'($signed(v[15:0]));
            2'd2:    extend = f3[2] ? XLEN'(v[31:0]) : XLEN'($signed(v[31:0]));
            default: extend = v;
        endcase
    endfunction

    assign o_req_ready = (state == S_IDLE) || (state == S_DONE);

    // Decode the incoming request; both beats' lane data come from one double-width shift.
    always_comb begin
        in_off      = i_addr[OFS_W-1:0];
        in_base     = {i_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        in_strb2    = {{LANES{1'b0}}, size_mask(i_funct3[1:0])} << in_off;
        in_data2    = {{XLEN{1'b0}}, i_wdata} << {in_off, 3'b000};
        in_misalign = (int'(in_off) & ((1 << i_funct3[1:0]) - 1)) != 0;
        in_split    = (int'(in_off) + (1 << i_funct3[1:0])) > LANES;
        in_illegal  = (i_we && i_funct3[2])
                   || ((XLEN == 32) && ((i_funct3[1:0] == 2'd3) || (i_funct3 == 3'b110)))
                   || ((XLEN == 64) && (i_funct3 == 3'b111));
        in_reject   = in_illegal || (in_misalign && !SPLIT_MISALIGNED);
    end

    // Merge the beat(s) of a load: beat 0 in the low half, beat 1 in the high half, shifted down by the offset.
    always_comb begin
        rd_lo       = (state == S_BEAT1) ? r_rd0 : i_mem_rdata;
        rd_hi       = (state == S_BEAT1) ? i_mem_rdata : '0;
        rd_merged   = XLEN'({rd_hi, rd_lo} >> {r_off, 3'b000});
        load_result = extend(rd_merged, r_funct3);
    end

    // Request sequencing, bus beat generation and completion reporting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_split     <= 1'b0;
            r_wstrb_hi  <= '0;
            r_wdata_hi  <= '0;
            r_rd0       <= '0;
            o_done      <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_misalign  <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wstrb <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_req) begin
                        r_we       <= i_we;
                        r_funct3   <= i_funct3;
                        r_off      <= in_off;
                        r_split    <= in_split;
                        r_wstrb_hi <= i_we ? in_strb2[2*LANES-1:LANES] : '0;
                        r_wdata_hi <= in_data2[2*XLEN-1:XLEN];
                        o_misalign <= in_misalign;
                        o_rdata    <= '0;
                        if (in_reject) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else begin
                            state       <= S_BEAT0;
                            o_err       <= 1'b0;
                            o_mem_valid <= 1'b1;
                            o_mem_we    <= i_we;
                            o_mem_addr  <= in_base;
                            o_mem_wstrb <= i_we ? in_strb2[LANES-1:0] : '0;
                            o_mem_wdata <= in_data2[XLEN-1:0];
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BEAT0: begin
                    if (i_mem_ready) begin
                        r_rd0 <= i_mem_rdata;
                        if (!i_mem_err && r_split) begin
                            state       <= S_BEAT1;
                            o_mem_addr  <= o_mem_addr + ADDR_W'(LANES);
                            o_mem_wstrb <= r_wstrb_hi;
                            o_mem_wdata <= r_wdata_hi;
                        end else begin
                            state       <= S_DONE;
                            o_mem_valid <= 1'b0;
                            o_done      <= 1'b1;
                            o_err       <= i_mem_err;
                            o_rdata     <= (r_we || i_mem_err) ? '0 : load_result;
                        end
                    end
                end
                S_BEAT1: begin
                    if (i_mem_ready) begin
                        state       <= S_DONE;
                        o_mem_valid <= 1'b0;
                        o_done      <= 1'b1;
                        o_err       <= i_mem_err;
                        o_rdata     <= (r_we || i_mem_err) ? '0 : load_result;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-memory model
module tb_load_store_unit;
    logic        clk;
    logic        rst_n;
    logic        req, req_ns;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        mem_ready, mem_err;
    logic [31:0] mem_rdata;

    logic        req_ready, done, err, misalign, mem_valid, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        ns_ready, ns_done, ns_err, ns_mis, ns_mem_valid, ns_mem_we;
    logic [31:0] ns_rdata, ns_mem_addr, ns_mem_wdata;
    logic [3:0]  ns_mem_wstrb;

    logic [7:0]  bus_mem [0:1023];
    logic [7:0]  ref_mem [0:1023];

    int wait_cfg [2];
    int err_cfg;
    int tx_start;
    int beat_total;
    int wcnt;
    logic [31:0] rec_addr  [4];
    logic [3:0]  rec_strb  [4];
    logic [31:0] rec_wdata [4];
    logic        rec_we    [4];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_req_ready(req_ready),
        .i_we(we), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
        .o_done(done), .o_rdata(rdata), .o_err(err), .o_misalign(misalign),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .i_mem_err(mem_err),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    load_store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_ns), .o_req_ready(ns_ready),
        .i_we(we), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
        .o_done(ns_done), .o_rdata(ns_rdata), .o_err(ns_err), .o_misalign(ns_mis),
        .o_mem_valid(ns_mem_valid), .i_mem_ready(1'b1), .i_mem_err(1'b0),
        .o_mem_we(ns_mem_we), .o_mem_addr(ns_mem_addr), .o_mem_wstrb(ns_mem_wstrb),
        .o_mem_wdata(ns_mem_wdata), .i_mem_rdata(32'h0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            bus_mem[(a + i) & 1023] = v[8*i +: 8];
            ref_mem[(a + i) & 1023] = v[8*i +: 8];
        end
    endtask

    // Memory responder: waits wait_cfg[beat] cycles, then accepts the beat and updates bus_mem.
    initial begin
        int cur, a;
        logic [36:0] held_f;
        logic [31:0] held_d;
        mem_ready  = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
        beat_total = 0;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (mem_ready) wcnt = 0;
            mem_ready = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = $urandom;
            if (!mem_valid) begin
                wcnt = 0;
            end else begin
                cur = beat_total - tx_start;
                if (wcnt == 0) begin
                    held_f = {mem_we, mem_wstrb, mem_addr};
                    held_d = mem_wdata;
                end else begin
                    check("beat_hold_ctl", {27'b0, mem_we, mem_wstrb, mem_addr}, {27'b0, held_f});
                    check("beat_hold_wdata", mem_wdata, held_d);
                end
                if (wcnt >= wait_cfg[(cur > 1) ? 1 : cur]) begin
                    a = int'(mem_addr[9:0]);
                    mem_ready = 1'b1;
                    mem_err   = (err_cfg == cur);
                    mem_rdata = {bus_mem[(a+3) & 1023], bus_mem[(a+2) & 1023], bus_mem[(a+1) & 1023], bus_mem[a]};
                    rec_addr[beat_total & 3]  = mem_addr;
                    rec_strb[beat_total & 3]  = mem_wstrb;
                    rec_wdata[beat_total & 3] = mem_wdata;
                    rec_we[beat_total & 3]    = mem_we;
                    if (mem_we && !mem_err)
                        for (int j = 0; j < 4; j++)
                            if (mem_wstrb[j]) bus_mem[(a + j) & 1023] = mem_wdata[8*j +: 8];
                    beat_total++;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Issue one access at the current negedge and check it against the byte-memory model.
    task automatic access(input logic w, input logic [2:0] fn, input int a, input logic [31:0] wd,
                          input int w0, input int w1, input int errb);
        int s, n, base, exp_beats, exp_lat, bt;
        logic illegal, mis, split, exp_err;
        logic [31:0] exp_rd;
        logic [63:0] got_win, exp_win;
        logic [3:0]  exp_strb;
        s       = 1 << fn[1:0];
        base    = a & ~3;
        illegal = (w && fn[2]) || (fn[1:0] == 2'd3) || (fn == 3'b110);
        mis     = ((a % 4) & (s - 1)) != 0;
        split   = ((a % 4) + s) > 4;
        exp_err = illegal || (errb == 0) || (split && errb == 1);
        if (illegal)                  begin exp_beats = 0; exp_lat = 1; end
        else if (split && errb != 0)  begin exp_beats = 2; exp_lat = 3 + w0 + w1; end
        else                          begin exp_beats = 1; exp_lat = 2 + w0; end
        exp_rd = '0;
        if (!w && !exp_err) begin
            for (int i = 0; i < s; i++) exp_rd[8*i +: 8] = ref_mem[(a + i) & 1023];
            if (!fn[2] && s < 4 && exp_rd[8*s-1])
                for (int i = 8*s; i < 32; i++) exp_rd[i] = 1'b1;
        end
        if (w && !illegal)
            for (int i = 0; i < s; i++)
                if (!exp_err || (split && errb == 1 && (a + i) < base + 4))
                    ref_mem[(a + i) & 1023] = wd[8*i +: 8];

        check("req_ready", req_ready, 1);
        wait_cfg[0] = w0; wait_cfg[1] = w1; err_cfg = errb; tx_start = beat_total;
        req = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        if (!illegal) check("no_bubble_valid", mem_valid, 1);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat);
        check("err", err, exp_err);
        check("misalign", misalign, mis);
        check("rdata", rdata, exp_rd);
        bt = beat_total - tx_start;
        check("beats", bt, exp_beats);
        for (int b = 0; b < exp_beats && b < bt; b++) begin
            for (int j = 0; j < 4; j++)
                exp_strb[j] = w && (base + 4*b + j >= a) && (base + 4*b + j < a + s);
            check("beat_addr", rec_addr[(tx_start + b) & 3], base + 4*b);
            check("beat_wstrb", rec_strb[(tx_start + b) & 3], exp_strb);
            check("beat_we", rec_we[(tx_start + b) & 3], w);
        end
        for (int i = 0; i < 8; i++) begin
            got_win[8*i +: 8] = bus_mem[(base + i) & 1023];
            exp_win[8*i +: 8] = ref_mem[(base + i) & 1023];
        end
        check("mem_window", got_win, exp_win);
    endtask

    initial begin
        logic [7:0] b;
        logic seen;
        rst_n = 1'b0; req = 1'b0; req_ns = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
        wait_cfg[0] = 0; wait_cfg[1] = 0; err_cfg = -1; tx_start = 0;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            bus_mem[i] = b;
            ref_mem[i] = b;
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_outs", {done, err, misalign, mem_valid, mem_we, mem_wstrb}, 0);
        check("rst_data", {rdata, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: LW with two wait states
        set_word(32'h100, 32'h8899AABB);
        access(1'b0, 3'b010, 32'h100, 32'h0, 2, 0, -1);
        check("t1_rdata", rdata, 32'h8899AABB);
        check("t1_addr", rec_addr[tx_start & 3], 32'h100);
        check("t1_wstrb", rec_strb[tx_start & 3], 4'b0000);
        // 2: LB / LBU sign handling
        set_word(32'h100, 32'h80123456);
        access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, -1);
        check("t2_lb", rdata, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 1, 0, -1);
        check("t2_lbu", rdata, 32'h00000080);
        // 3: SH at offset 2
        access(1'b1, 3'b001, 32'h102, 32'h00001234, 0, 0, -1);
        check("t3_wstrb", rec_strb[tx_start & 3], 4'b1100);
        check("t3_wdata", rec_wdata[tx_start & 3], 32'h12340000);
        // 4: split SW
        access(1'b1, 3'b010, 32'h0FE, 32'hDEADBEEF, 1, 1, -1);
        check("t4_b0_addr", rec_addr[tx_start & 3], 32'h0FC);
        check("t4_b0_wdata", rec_wdata[tx_start & 3], 32'hBEEF0000);
        check("t4_b1_addr", rec_addr[(tx_start + 1) & 3], 32'h100);
        check("t4_b1_wstrb", rec_strb[(tx_start + 1) & 3], 4'b0011);
        check("t4_b1_wdata", rec_wdata[(tx_start + 1) & 3], 32'h0000DEAD);
        // 4b: the non-splitting instance rejects the same store, accepts an aligned load
        req_ns = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0FE; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_ns = 1'b0;
        check("ns_reject", {ns_mem_valid, ns_done, ns_err, ns_mis}, 4'b0111);
        req_ns = 1'b1; we = 1'b0; addr = 32'h100;
        @(negedge clk);
        req_ns = 1'b0;
        check("ns_aligned_beat", {ns_mem_valid, ns_done}, 2'b10);
        @(negedge clk);
        check("ns_aligned_done", {ns_mem_valid, ns_done, ns_err, ns_mis}, 4'b0100);
        // 5: split LW merge, then bus error on beat 0
        set_word(32'h0FC, 32'h33445566);
        set_word(32'h100, 32'h77881122);
        access(1'b0, 3'b010, 32'h0FE, 32'h0, 0, 2, -1);
        check("t5_merge", rdata, 32'h11223344);
        access(1'b0, 3'b010, 32'h0FE, 32'h0, 1, 0, 0);
        check("t5_err_rdata", {err, rdata}, {1'b1, 32'h0});
        // split store failing on beat 1 keeps beat 0; illegal encodings
        access(1'b1, 3'b010, 32'h1FD, 32'hCAFEF00D, 0, 1, 1);
        access(1'b1, 3'b100, 32'h200, 32'h12345678, 0, 0, -1);
        access(1'b0, 3'b011, 32'h200, 32'h0, 0, 0, -1);
        access(1'b0, 3'b110, 32'h200, 32'h0, 0, 0, -1);
        // 6: reset while beat 0 waits
        wait_cfg[0] = 6; err_cfg = -1; tx_start = beat_total;
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_before", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_valid", mem_valid, 0);
        check("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | done;
        end
        check("rst_mid_no_done", seen, 0);
        // back-to-back loads issued in DONE
        access(1'b0, 3'b010, 32'h200, 32'h0, 0, 0, -1);
        access(1'b0, 3'b010, 32'h204, 32'h0, 0, 0, -1);
        access(1'b0, 3'b001, 32'h206, 32'h0, 1, 0, -1);

        for (int k = 0; k < 200; k++) begin
            int e;
            e = $urandom_range(0, 7);
            access(1'($urandom), 3'($urandom), $urandom_range(0, 1015), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), (e == 0) ? 0 : ((e == 1) ? 1 : -1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
